// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM states and
// register-select encodings used by the controller and its bus decoder.
package alu_seq_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_INC = 3'b100;
    localparam logic [2:0] OP_DEC = 3'b101;
    localparam logic [2:0] OP_ADD = 3'b110;
    localparam logic [2:0] OP_SUB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic REG_R1 = 1'b0;
    localparam logic REG_R2 = 1'b1;

endpackage

// File: rtl/alu_seq_bus_decode.sv
// Decodes sequencer state into the datapath's active-low register load and
// A-bus output enables; at most one register ever drives the A bus.
module alu_seq_bus_decode
    import alu_seq_pkg::*;
(
    input  state_e state,
    input  logic   k_zero,
    input  logic   src,
    input  logic   dst,
    output logic   ei1_n,
    output logic   ei2_n,
    output logic   eo1_n,
    output logic   eo2_n
);

    logic a_sel;

    // First iteration reads the source; later ones accumulate on the destination.
    assign a_sel = k_zero ? src : dst;

    always_comb begin
        // NOTE: every output gets a default before the case logic so no latch is inferred.
        ei1_n = 1'b1;
        ei2_n = 1'b1;
        eo1_n = 1'b1;
        eo2_n = 1'b1;
        if (state == ST_EXEC) begin
            eo1_n = (a_sel != REG_R1);
            eo2_n = ~eo1_n;
            ei1_n = (dst != REG_R1);
            ei2_n = ~ei1_n;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven controller for the two-register sequential ALU datapath:
// repeats one ALU op rep+1 times into the destination and reports result/carry.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 3
) (
    input  logic             clk,
    input  logic             MR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_src,
    input  logic             cmd_dst,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic [WIDTH-1:0] dp_Y,
    input  logic             dp_CO,
    output logic [2:0]       dp_sel,
    output logic [WIDTH-1:0] dp_B,
    output logic             dp_EIbar1,
    output logic             dp_EIbar2,
    output logic             dp_EObar1,
    output logic             dp_EObar2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam logic [REP_W-1:0] K_ONE = REP_W'(1);

    state_e             state_q,  state_d;
    logic [2:0]         op_q,     op_d;
    logic               src_q,    src_d;
    logic               dst_q,    dst_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [REP_W-1:0]   rep_q,    rep_d;
    logic [REP_W-1:0]   k_q,      k_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q,  carry_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        src_d    = src_q;
        dst_d    = dst_q;
        b_d      = b_q;
        rep_d    = rep_q;
        k_d      = k_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    src_d   = cmd_src;
                    dst_d   = cmd_dst;
                    b_d     = cmd_b;
                    rep_d   = cmd_rep;
                    k_d     = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = dp_Y;
                // The accumulator restarts on the first capture so the old carry stays visible until then.
                carry_d  = ((k_q == '0) ? 1'b0 : carry_q) | dp_CO;
                if (k_q == rep_q) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge MR) begin
        if (MR) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            src_q    <= REG_R1;
            dst_q    <= REG_R1;
            b_q      <= '0;
            rep_q    <= '0;
            k_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            b_q      <= b_d;
            rep_q    <= rep_d;
            k_q      <= k_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    alu_seq_bus_decode u_bus_decode (
        .state  (state_q),
        .k_zero (k_q == '0),
        .src    (src_q),
        .dst    (dst_q),
        .ei1_n  (dp_EIbar1),
        .ei2_n  (dp_EIbar2),
        .eo1_n  (dp_EObar1),
        .eo2_n  (dp_EObar2)
    );

    assign dp_sel    = op_q;
    assign dp_B      = b_q;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural two-register ALU
// datapath model wired to the controller's enables.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       MR  = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op  = '0;
    logic       cmd_src = 1'b0;
    logic       cmd_dst = 1'b0;
    logic [3:0] cmd_b   = '0;
    logic [2:0] cmd_rep = '0;
    logic [3:0] dp_Y;
    logic       dp_CO;
    logic [2:0] dp_sel;
    logic [3:0] dp_B;
    logic       dp_EIbar1, dp_EIbar2, dp_EObar1, dp_EObar2;
    logic       busy, done, carry;
    logic [3:0] result;

    int checks   = 0;
    int failures = 0;

    logic [3:0] prev_result;
    logic       prev_carry;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(4), .REP_W(3)) dut (
        .clk       (clk),
        .MR        (MR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_b     (cmd_b),
        .cmd_rep   (cmd_rep),
        .dp_Y      (dp_Y),
        .dp_CO     (dp_CO),
        .dp_sel    (dp_sel),
        .dp_B      (dp_B),
        .dp_EIbar1 (dp_EIbar1),
        .dp_EIbar2 (dp_EIbar2),
        .dp_EObar1 (dp_EObar1),
        .dp_EObar2 (dp_EObar2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry     (carry)
    );

    // Datapath model: R1/R2, shared A bus, ALU.
    logic [3:0] r1, r2, a_bus;
    logic [4:0] alu_sum;

    always_comb begin
        a_bus = 4'h0;
        if (!dp_EObar1) a_bus = r1;
        else if (!dp_EObar2) a_bus = r2;
    end

    always_comb begin
        alu_sum = 5'h0;
        case (dp_sel)
            OP_NOT: alu_sum = {1'b0, ~a_bus};
            OP_AND: alu_sum = {1'b0, a_bus & dp_B};
            OP_OR:  alu_sum = {1'b0, a_bus | dp_B};
            OP_XOR: alu_sum = {1'b0, a_bus ^ dp_B};
            OP_INC: alu_sum = {1'b0, a_bus} + 5'd1;
            OP_DEC: alu_sum = {(a_bus == 4'h0), a_bus - 4'd1};
            OP_ADD: alu_sum = {1'b0, a_bus} + {1'b0, dp_B};
            OP_SUB: alu_sum = {(a_bus < dp_B), a_bus - dp_B};
            default: alu_sum = 5'h0;
        endcase
    end

    assign dp_Y  = alu_sum[3:0];
    assign dp_CO = alu_sum[4];

    always @(posedge clk or posedge MR) begin
        if (MR) begin
            r1 <= 4'h0;
            r2 <= 4'h0;
        end else begin
            if (!dp_EIbar1) r1 <= dp_Y;
            if (!dp_EIbar2) r2 <= dp_Y;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Both registers must never drive the A bus together.
    always @(negedge clk) begin
        check("no_bus_contention", 32'(dp_EObar1 | dp_EObar2), 32'd1);
    end

    task automatic start_cmd(input logic [2:0] op, input logic src, input logic dst,
                             input logic [3:0] b, input logic [2:0] rep);
        cmd_op    = op;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_b     = b;
        cmd_rep   = rep;
        cmd_valid = 1'b1;
    endtask

    // Expects the DUT idle with a command presented; covers accept through return to IDLE.
    task automatic run_cmd(input logic [2:0] op, input logic src, input logic dst,
                           input logic [3:0] b, input logic [2:0] rep,
                           input logic [3:0] exp_res, input logic exp_co);
        logic a_src;
        @(posedge clk); #1;
        // Scramble fields and keep valid high: a busy controller must ignore them.
        cmd_op  = ~op;
        cmd_b   = ~b;
        cmd_rep = ~rep;
        cmd_src = ~src;
        cmd_dst = ~dst;
        for (int i = 0; i <= int'(rep); i++) begin
            a_src = (i == 0) ? src : dst;
            check("exec_status", {busy, done, cmd_ready}, 3'b100);
            check("exec_sel", dp_sel, op);
            check("exec_b", dp_B, b);
            check("exec_enables", {dp_EIbar1, dp_EIbar2, dp_EObar1, dp_EObar2},
                  {dst != REG_R1, dst != REG_R2, a_src != REG_R1, a_src != REG_R2});
            if (i == 0) begin
                check("result_hold", result, prev_result);
                check("carry_hold", carry, prev_carry);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("done_status", {busy, done, cmd_ready}, 3'b110);
        check("done_enables", {dp_EIbar1, dp_EIbar2, dp_EObar1, dp_EObar2}, 4'hF);
        check("done_result", result, exp_res);
        check("done_carry", carry, exp_co);
        @(posedge clk); #1;
        check("idle_status", {busy, done, cmd_ready}, 3'b001);
        prev_result = exp_res;
        prev_carry  = exp_co;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset pulse starting mid-cycle.
        #3 MR = 1'b1;
        #1;
        check("rst_status", {busy, done, cmd_ready}, 3'b001);
        check("rst_enables", {dp_EIbar1, dp_EIbar2, dp_EObar1, dp_EObar2}, 4'hF);
        check("rst_sel_b", {dp_sel, dp_B}, 7'h00);
        check("rst_result", {result, carry}, 5'h00);
        #13 MR = 1'b0;
        @(posedge clk); #1;
        check("post_rst_status", {busy, done, cmd_ready}, 3'b001);
        check("post_rst_enables", {dp_EIbar1, dp_EIbar2, dp_EObar1, dp_EObar2}, 4'hF);
        check("post_rst_result", result, 4'h0);
        prev_result = 4'h0;
        prev_carry  = 1'b0;

        // INC R1->R1, three iterations: 0 -> 3.
        start_cmd(OP_INC, REG_R1, REG_R1, 4'h0, 3'd2);
        run_cmd(OP_INC, REG_R1, REG_R1, 4'h0, 3'd2, 4'h3, 1'b0);
        check("inc_r1", r1, 4'h3);

        // ADD R1(3)+5 -> R2 = 8.
        start_cmd(OP_ADD, REG_R1, REG_R2, 4'h5, 3'd0);
        run_cmd(OP_ADD, REG_R1, REG_R2, 4'h5, 3'd0, 4'h8, 1'b0);
        check("add_r2", r2, 4'h8);

        // ADD R2(8)+8 -> R2 wraps to 0 with carry.
        start_cmd(OP_ADD, REG_R2, REG_R2, 4'h8, 3'd0);
        run_cmd(OP_ADD, REG_R2, REG_R2, 4'h8, 3'd0, 4'h0, 1'b1);
        check("add_wrap_r2", r2, 4'h0);

        // XOR R1(3)^3 -> R1 = 0; carry accumulator restarts.
        start_cmd(OP_XOR, REG_R1, REG_R1, 4'h3, 3'd0);
        run_cmd(OP_XOR, REG_R1, REG_R1, 4'h3, 3'd0, 4'h0, 1'b0);
        check("xor_r1", r1, 4'h0);

        // Multiply by add: R2 = 0 + 3*4 = 12, source switches after iteration 0.
        start_cmd(OP_ADD, REG_R1, REG_R2, 4'h3, 3'd3);
        run_cmd(OP_ADD, REG_R1, REG_R2, 4'h3, 3'd3, 4'hC, 1'b0);
        check("mul_r2", r2, 4'hC);

        // SUB rep=7 aborted by MR in the fourth EXEC cycle.
        start_cmd(OP_SUB, REG_R1, REG_R1, 4'h1, 3'd7);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_status", {busy, done, cmd_ready}, 3'b100);
        check("abort_pre_r1", r1, 4'hD);
        #2 MR = 1'b1;
        #1;
        check("abort_status", {busy, done, cmd_ready}, 3'b001);
        check("abort_enables", {dp_EIbar1, dp_EIbar2, dp_EObar1, dp_EObar2}, 4'hF);
        check("abort_result", {result, carry}, 5'h00);
        check("abort_dp_clear", {r1, r2}, 8'h00);
        start_cmd(OP_INC, REG_R1, REG_R1, 4'h0, 3'd7);
        @(posedge clk); #1;
        check("abort_held_idle", {busy, done, cmd_ready}, 3'b001);
        MR = 1'b0;
        prev_result = 4'h0;
        prev_carry  = 1'b0;

        // Accepted on the first edge after MR drops; rep all-ones runs 8 iterations.
        run_cmd(OP_INC, REG_R1, REG_R1, 4'h0, 3'd7, 4'h8, 1'b0);
        check("inc8_r1", r1, 4'h8);

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-driven controller for the two-register sequential ALU datapath (registers R1/R2, shared A bus, 3-bit ALU select, external B operand).
- Accepts one command per valid/ready handshake.
- Drives the datapath's active-low register input enables (EIbar1/2) and output enables (EObar1/2), the ALU select and the B operand.
- Repeats the operation a programmable number of times, accumulating into the destination register, which gives multiply-by-add and count-by-increment.
- Reports result and sticky carry with a one-cycle done pulse.

Parameters:
WIDTH, 4, datapath word width (B, Y, result).
REP_W, 3, width of the repeat-count field; maximum iterations = 2**REP_W.

Ports:
clk  in  1  system clock, rising edge.
MR  in  1  master reset, asynchronous, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  controller can accept a command.
cmd_op  in  3  ALU select code for the command.
cmd_src  in  1  A source for iteration 0 (0=R1, 1=R2).
cmd_dst  in  1  destination register (0=R1, 1=R2).
cmd_b  in  WIDTH  B operand, held for the whole command.
cmd_rep  in  REP_W  extra iterations (total = cmd_rep+1).
dp_Y  in  WIDTH  ALU result from datapath.
dp_CO  in  1  ALU carry/borrow from datapath.
dp_sel  out  3  ALU select to datapath.
dp_B  out  WIDTH  B operand to datapath.
dp_EIbar1  out  1  R1 load enable, active-low (1 = hold).
dp_EIbar2  out  1  R2 load enable, active-low.
dp_EObar1  out  1  R1 drives A bus, active-low.
dp_EObar2  out  1  R2 drives A bus, active-low.
busy  out  1  command in progress (EXEC or DONE).
done  out  1  one-cycle pulse, result/carry valid.
result  out  WIDTH  last Y captured.
carry  out  1  OR of dp_CO over all iterations.

Behaviour:
- Clock and reset: one clock, clk. Reset MR is asynchronous and active-high.
- Values while MR is high:
  - state=IDLE, cmd_ready=1, busy=0, done=0.
  - dp_EIbar1=dp_EIbar2=1, dp_EObar1=dp_EObar2=1 (A bus floating).
  - dp_sel=000, dp_B=0, result=0, carry=0, iteration counter=0.
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1; all enables deasserted (1).
  - On a rising edge with cmd_valid=1: latch op/src/dst/b/rep, clear iteration counter k and carry accumulator, go to EXEC.
- EXEC (one clock per iteration):
  - dp_sel=op, dp_B=b.
  - A source = src when k==0, otherwise dst. The matching EObar is low and the other is high.
  - The EIbar of dst is low and the other is high.
  - At the rising edge: the datapath loads Y into dst; the controller captures result<=dp_Y and carry<=carry|dp_CO.
  - If k==rep go to DONE, else k<=k+1.
- DONE: done=1, busy=1, cmd_ready=0, all enables high. Next edge goes to IDLE.
- result and carry hold until the next command's first EXEC capture.
- Latency: accept edge T. EXEC occupies cycles T+1 .. T+rep+1. done is high in cycle T+rep+2. The next accept is no earlier than T+rep+3.
- Invariant, every cycle: dp_EObar1 and dp_EObar2 are never both 0 (bus contention).
- Counter k is REP_W bits. rep = all-ones runs 2**REP_W iterations without wrap error; the k==rep comparison terminates before overflow.
- Unary ops (NOT, INC, DEC) still drive dp_B=b; the datapath ignores it.
- carry is sticky across iterations. Logic ops contribute 0.
- cmd_valid while not ready: ignored, no latch. Command fields may change freely then.
- MR asserted mid-command:
  - Immediate return to IDLE, all enables high, no done pulse.
  - Datapath registers are cleared by the same MR.
- All outputs are registered or decoded from registered state only. No combinational path from cmd_* to dp_*.

Decomposition:
- Package alu_seq_pkg holds:
  - Op code constants: NOT=000, AND=001, OR=010, XOR=011, INC=100, DEC=101, ADD=110, SUB=111.
  - State enum {IDLE, EXEC, DONE}.
  - Register-select constants R1=0, R2=1.
- One sub-module, alu_seq_bus_decode (combinational): maps {state, k==0, src, dst} to the four active-low enables and enforces the no-dual-drive invariant.

Test Plan:
- MR pulse mid-cycle, then release -> cmd_ready=1; all dp_EIbar/dp_EObar=1; result=0000; done=0.
- INC, src=R1, dst=R1, rep=2, from reset -> EXEC for 3 cycles, R1=0011, done in cycle T+4, result=0011, carry=0.
- ADD, src=R1(0011), dst=R2, B=0101, rep=0 -> R2=1000, result=1000, carry=0.
- ADD, src=R2(1000), dst=R2, B=1000, rep=0 -> result=0000, carry=1. Then XOR, src=R1, dst=R1, B=0011 -> R1=0000, carry=0.
- ADD, src=R1(0000), dst=R2, B=0011, rep=3 -> iteration 0 drives dp_EObar1=0, iterations 1-3 drive dp_EObar2=0; result=1100, carry=0. A monitor confirms EObar1 and EObar2 are never both low.
- SUB, src=R1, dst=R1, B=0001, rep=7, MR asserted during the 4th EXEC cycle -> no done, immediate IDLE, enables high; a new command is accepted on the first edge after MR drops.
